fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Pipeline IF stage: owns PCF, issues single-outstanding instruction-memory reads, registers the IF/ID
//  pipeline (InstrD/PCD/PCPlus4D/ValidD). Directly upstream of decode; consumes StallF/StallD/FlushD from
//  the hazard unit and PCSrcE/PCTargetE from execute. Inserts NOP bubbles on memory latency; one-entry skid
//  buffer absorbs a response returning during a decode stall.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PCF value after reset
//  NOP_INSTR 32'h0000_0013  bubble encoding (addi x0,x0,0)
// PORTS
//  clk        in  1   clock, all state on rising edge
//  rst        in  1   reset, synchronous, active-high
//  StallF     in  1   hold PCF (load-use)
//  StallD     in  1   hold IF/ID register
//  FlushD     in  1   squash IF/ID (branch taken)
//  PCSrcE     in  1   redirect fetch to PCTargetE
//  PCTargetE  in  32  redirect target; bits [1:0] forced to 0
//  imem_req   out 1   read request; held high until imem_rvalid
//  imem_addr  out 32  read address (PCF at issue), stable while imem_req=1
//  imem_rvalid in 1   response valid, >=1 cycle after request accepted
//  imem_rdata in  32  response data, valid with imem_rvalid
//  InstrD     out 32  decode instruction
//  PCD        out 32  decode PC
//  PCPlus4D   out 32  PCD+4
//  ValidD     out 1   1=real instruction, 0=bubble
//  bubble_cnt out 32  bubbles inserted (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at edge): PCF=RESET_PC, state=IDLE, imem_req=0, skid empty, drop=0, InstrD=NOP_INSTR,
//   PCD=0, PCPlus4D=0, ValidD=0, bubble_cnt=0. Reset mid-request abandons it; memory must tolerate this.
//  FSM: IDLE -> REQ (1 cycle after rst deasserts). REQ: imem_req=1, imem_addr=PCF; stays until imem_rvalid.
//   On rvalid with drop=0: deliver (below), back to REQ with next PC, or HOLD if instr went to skid.
//   HOLD: imem_req=0 until skid drains to D, then REQ.
//  Deliver: if FlushD -> discard; elif StallD -> skid<=rdata (with PCF); else D<=rdata, PCD<=PCF,
//   PCPlus4D<=PCF+4, ValidD=1. PCF<=PCF+4 only when an instruction is accepted (to D or skid) and StallF=0.
//  Best-case throughput 1 instr per (memory latency + 1) cycles; latency-1 memory -> 1 instr / 2 cycles.
//  IF/ID update priority per cycle: FlushD > StallD > skid drain > fresh response > bubble.
//   FlushD: InstrD=NOP_INSTR, ValidD=0, skid cleared. StallD: all D outputs hold.
//   No instruction available, StallD=0: InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D hold, bubble_cnt+1.
//  Redirect (PCSrcE=1) beats StallF: PCF<={PCTargetE[31:2],2'b00}; skid cleared. In REQ with no rvalid
//   this cycle: drop=1, imem_req stays high with old address until rvalid, response discarded, drop=0,
//   new request at target next cycle. rvalid same cycle as PCSrcE: response discarded, REQ at target next.
//  Arithmetic: PC+4 modulo 2^32 (32'hFFFF_FFFC -> 0). bubble_cnt saturates at 32'hFFFF_FFFF.
//  StallF=1, StallD=0 (illegal from hazard unit): PCF holds; accepted instr still advances D.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: bubble_cnt counts as above. Undefined: counter logic absent,
//   bubble_cnt tied to 32'h0. Fetch behaviour identical in both builds.
// TESTING
//  Reset, latency-1 memory returning PC>>2 -> D sees PCD 0,4,8 with ValidD=1 every 2nd cycle, NOP between.
//  StallD=StallF=1 for 3 cycles while rvalid arrives -> D holds, skid fills, imem_req=0; release -> skid
//   instr enters D next cycle, then new request at PCF+4.
//  Latency-3 memory, PCSrcE=1 PCTargetE=32'h100 mid-wait -> stale data never reaches D; next real PCD=0x100.
//  PCSrcE with PCTargetE=32'h203 same cycle as rvalid -> response dropped, imem_addr=0x200 next cycle.
//  FlushD=1 with StallD=1 -> InstrD=32'h13, ValidD=0; skid cleared.
//  RESET_PC=32'hFFFF_FFFC -> PCPlus4D=0, next imem_addr=0; FETCH_PERF_CNT_EN on/off bubble_cnt = 5 / 0
//   after 5 bubbles.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory read channel between the fetch stage (master) and the
// instruction memory (slave). Single outstanding request: imem_req is held
// with a stable imem_addr until imem_rvalid returns the data.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Pipeline IF stage: owns PCF, issues single-outstanding instruction-memory
// reads, and registers the IF/ID pipeline (InstrD/PCD/PCPlus4D/ValidD).
// A one-entry skid buffer catches a response that returns while decode is
// stalled. Bubbles (NOP_INSTR, ValidD=0) fill cycles with no instruction.
// Build option: define FETCH_PERF_CNT_EN to enable the saturating bubble
// counter on bubble_cnt; otherwise bubble_cnt is tied to zero.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 PCSrcE,
    input  logic [31:0]          PCTargetE,
    fetch_stage_if.master        imem,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD,
    output logic [31:0]          bubble_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic        r_drop;

    logic [31:0] r_pcf;
    logic        r_inc_pend;

    logic        r_skid_v;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pcp4_d;
    logic        r_valid_d;

    logic [31:0] w_target;
    logic        w_resp;
    logic        w_live;
    logic        w_to_skid;
    logic        w_to_d;
    logic        w_accept;
    logic        w_drain;
    logic [31:0] w_pcf_next;
    logic        w_pend_next;
    logic        w_skid_v_next;

    assign w_target  = PCTargetE & 32'hFFFF_FFFC;

    // A response counts only while a request is outstanding; a pending or
    // same-cycle redirect turns it into a stale response to be discarded.
    assign w_resp    = (r_state == S_REQ) && imem.imem_rvalid;
    assign w_live    = w_resp && !r_drop && !PCSrcE;
    assign w_to_skid = w_live && !FlushD && StallD;
    assign w_to_d    = w_live && !FlushD && !StallD;
    assign w_accept  = w_to_skid || w_to_d;

    // Skid contents are on the old path once a redirect arrives, so no drain then.
    assign w_drain   = r_skid_v && !FlushD && !StallD && !PCSrcE;

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;

    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pcp4_d;
    assign ValidD   = r_valid_d;

    // Next PCF: redirect wins over StallF; an instruction accepted under
    // StallF defers its +4 until StallF drops so it is never fetched twice.
    always_comb begin
        w_pcf_next  = r_pcf;
        w_pend_next = r_inc_pend;
        if (PCSrcE) begin
            w_pcf_next  = w_target;
            w_pend_next = 1'b0;
        end else if (w_accept) begin
            if (StallF) begin
                w_pend_next = 1'b1;
            end else begin
                w_pcf_next = r_pcf + 32'd4;
            end
        end else if (r_inc_pend && !StallF) begin
            w_pcf_next  = r_pcf + 32'd4;
            w_pend_next = 1'b0;
        end
    end

    // Next skid occupancy: flush and redirect empty it, a stalled response fills it.
    always_comb begin
        w_skid_v_next = r_skid_v;
        if (PCSrcE || FlushD) begin
            w_skid_v_next = 1'b0;
        end else if (w_to_skid) begin
            w_skid_v_next = 1'b1;
        end else if (w_drain) begin
            w_skid_v_next = 1'b0;
        end
    end

    // Request FSM: a new request is issued only once the next PCF is final
    // (skid empty, no deferred increment), so imem_addr never moves under a request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                    r_addr  <= w_pcf_next;
                end
                S_REQ: begin
                    if (!imem.imem_rvalid) begin
                        if (PCSrcE) begin
                            r_drop <= 1'b1;
                        end
                    end else begin
                        r_drop <= 1'b0;
                        if (w_skid_v_next || w_pend_next) begin
                            r_state <= S_HOLD;
                            r_req   <= 1'b0;
                        end else begin
                            r_req  <= 1'b1;
                            r_addr <= w_pcf_next;
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_skid_v_next && !w_pend_next) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= w_pcf_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // PCF and skid buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcf        <= RESET_PC;
            r_inc_pend   <= 1'b0;
            r_skid_v     <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
        end else begin
            r_pcf      <= w_pcf_next;
            r_inc_pend <= w_pend_next;
            r_skid_v   <= w_skid_v_next;
            if (w_to_skid) begin
                r_skid_instr <= imem.imem_rdata;
                r_skid_pc    <= r_pcf;
            end
        end
    end

    // IF/ID register, priority: flush > stall > skid drain > fresh response > bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= '0;
            r_pcp4_d  <= '0;
            r_valid_d <= 1'b0;
        end else if (FlushD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (w_drain) begin
                r_instr_d <= r_skid_instr;
                r_pc_d    <= r_skid_pc;
                r_pcp4_d  <= r_skid_pc + 32'd4;
                r_valid_d <= 1'b1;
            end else if (w_to_d) begin
                r_instr_d <= imem.imem_rdata;
                r_pc_d    <= r_pcf;
                r_pcp4_d  <= r_pcf + 32'd4;
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_bubble;
    logic [31:0] r_bubble_cnt;

    assign w_bubble   = !FlushD && !StallD && !w_drain && !w_to_d;
    assign bubble_cnt = r_bubble_cnt;

    // Saturating count of bubbles inserted into decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end
`else
    assign bubble_cnt = '0;
`endif

endmodule
